// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB and drives datapath strobes.
// Latency (zero-wait memories): R/I 4 cycles, BRANCH 3, STORE 4, LOAD 5, counted from FETCH entry.
// Backpressure: stalls in FETCH/MEM until imem_ready/mem_ready; traps after MEM_TIMEOUT+1 idle cycles.
module control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic [3:0]  alu_op,
  output logic        trap,
  output logic [2:0]  state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH
  } iclass_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    opcode_q;
  logic [2:0]    funct3_q;
  logic          f7b5_q;
  iclass_t       cls_q, dec_cls;
  logic [3:0]    alu_op_q, dec_alu_op;
  logic          alu_src_q, dec_alu_src;
  logic          mem_to_reg_q, dec_mem_to_reg;
  logic          alt;

  logic imem_req_c, ir_write_c, pc_write_c, reg_write_c;
  logic mem_read_c, mem_write_c, branch_c;

  // Only opcode, funct3 and funct7[5] steer control; register/immediate fields belong to the datapath.
  logic unused_rdata_bits;
  assign unused_rdata_bits = ^{imem_rdata[31], imem_rdata[29:15], imem_rdata[11:7]};

  // Decode the latched instruction fields into class and ALU controls.
  always_comb begin
    dec_cls        = C_NONE;
    dec_alu_op     = 4'b0000;
    dec_alu_src    = 1'b0;
    dec_mem_to_reg = 1'b0;
    // funct7[5] picks sub/sra for R-type, but for I-type only srai uses it (addi imm bit 10 is data).
    alt = f7b5_q & ((opcode_q == OP_R) | (funct3_q == 3'b101));
    case (opcode_q)
      OP_R:      dec_cls = C_R;
      OP_I:      dec_cls = C_I;
      OP_LOAD:   dec_cls = C_LOAD;
      OP_STORE:  dec_cls = C_STORE;
      OP_BRANCH: dec_cls = C_BRANCH;
      default:   dec_cls = C_NONE;
    endcase
    if (dec_cls == C_R || dec_cls == C_I) begin
      case (funct3_q)
        3'b000:  dec_alu_op = alt ? 4'b0001 : 4'b0000;
        3'b001:  dec_alu_op = 4'b0101;
        3'b010:  dec_alu_op = 4'b1000;
        3'b011:  dec_alu_op = 4'b1001;
        3'b100:  dec_alu_op = 4'b0100;
        3'b101:  dec_alu_op = alt ? 4'b0111 : 4'b0110;
        3'b110:  dec_alu_op = 4'b0011;
        default: dec_alu_op = 4'b0010;
      endcase
    end else if (dec_cls == C_BRANCH) begin
      dec_alu_op = 4'b0001;
    end
    dec_alu_src    = (dec_cls == C_I) || (dec_cls == C_LOAD) || (dec_cls == C_STORE);
    dec_mem_to_reg = (dec_cls == C_LOAD);
  end

  // Next state, timeout counter and per-state strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    imem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    branch_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (cnt_q == TMO) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: state_d = (dec_cls == C_NONE) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          C_BRANCH: begin
            branch_c   = 1'b1;
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
            cnt_d      = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read_c  = (cls_q == C_LOAD);
        mem_write_c = (cls_q == C_STORE);
        // Ready on the final counted cycle still completes the access.
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
            cnt_d      = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TMO) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_d     = S_FETCH;
        cnt_d       = '0;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the control-relevant instruction fields when the fetch completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_q <= '0;
      funct3_q <= '0;
      f7b5_q   <= 1'b0;
    end else if (state_q == S_FETCH && imem_ready) begin
      opcode_q <= imem_rdata[6:0];
      funct3_q <= imem_rdata[14:12];
      f7b5_q   <= imem_rdata[30];
    end
  end

  // Register decoded controls in DECODE; they hold through EXECUTE/MEM/WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_q        <= C_NONE;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (state_q == S_DECODE && dec_cls != C_NONE) begin
      cls_q        <= dec_cls;
      alu_op_q     <= dec_alu_op;
      alu_src_q    <= dec_alu_src;
      mem_to_reg_q <= dec_mem_to_reg;
    end
  end

  // Strobes are forced low while reset is held so an aborted instruction leaves no side effects.
  assign imem_req   = reset & imem_req_c;
  assign ir_write   = reset & ir_write_c;
  assign pc_write   = reset & pc_write_c;
  assign reg_write  = reset & reg_write_c;
  assign mem_read   = reset & mem_read_c;
  assign mem_write  = reset & mem_write_c;
  assign branch     = reset & branch_c;
  assign trap       = (state_q == S_TRAP);
  assign alu_op     = trap ? 4'b0000 : alu_op_q;
  assign alu_src    = ~trap & alu_src_q;
  assign mem_to_reg = ~trap & mem_to_reg_q;
  assign state      = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-scenario tasks with inline expected values.
// Inputs driven 2 time units after each rising edge; outputs sampled 1 unit later.
// Ends with a single summary line of error and check counts.
module tb_control_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        mem_ready;
  logic        imem_req, ir_write, pc_write, reg_write, alu_src, mem_to_reg;
  logic        mem_read, mem_write, branch, trap;
  logic [3:0]  alu_op;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .mem_ready(mem_ready), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .alu_op(alu_op), .trap(trap), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_ready = 1'b0;
    mem_ready = 1'b0;
    imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_ready = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({imem_req, ir_write, pc_write, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, trap} !== 10'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0", {imem_req, ir_write, pc_write, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, trap});
    end
    checks++;
    if ({state, alu_op} !== 7'b0) begin
      errors++; $display("FAIL reset_state_aluop: got %b expected 0", {state, alu_op});
    end
  endtask

  task automatic test_addi();
    do_reset();
    imem_rdata = 32'h00500113; imem_ready = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, imem_req, ir_write} !== {3'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL addi_fetch: got %b expected 00011", {state, imem_req, ir_write});
    end
    tick();
    checks++;
    if ({state, ir_write} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL addi_decode: got %b expected 0010", {state, ir_write});
    end
    imem_ready = 1'b0;
    tick();
    checks++;
    if ({state, alu_src, alu_op, reg_write} !== {3'd2, 1'b1, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL addi_exec: got %b expected 010100000", {state, alu_src, alu_op, reg_write});
    end
    tick();
    checks++;
    if ({state, reg_write, alu_src, alu_op, pc_write} !== {3'd4, 1'b1, 1'b1, 4'b0000, 1'b1}) begin
      errors++; $display("FAIL addi_wb: got %b expected 1001100001", {state, reg_write, alu_src, alu_op, pc_write});
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL addi_next_fetch: got %0d expected 0", state);
    end
  endtask

  task automatic test_sub();
    do_reset();
    imem_rdata = 32'h40310233; imem_ready = 1'b1; mem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    checks++;
    if ({state, alu_op, alu_src, reg_write} !== {3'd2, 4'b0001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_exec: got %b expected 010000100", {state, alu_op, alu_src, reg_write});
    end
    tick();
    checks++;
    if ({state, alu_op, alu_src, reg_write, pc_write} !== {3'd4, 4'b0001, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_wb: got %b expected 1000001011", {state, alu_op, alu_src, reg_write, pc_write});
    end
  endtask

  task automatic test_store_wait();
    int mw, mr, rw, pc_c;
    mw = 0; mr = 0; rw = 0; pc_c = -1;
    do_reset();
    imem_rdata = 32'h00202023;
    for (int c = 0; c < 8; c++) begin
      imem_ready = (c == 0);
      mem_ready = (c == 6);
      #1;
      if (mem_write) mw++;
      if (mem_read) mr++;
      if (reg_write) rw++;
      if (pc_write) pc_c = c;
      tick();
    end
    checks++;
    if (mw !== 4) begin
      errors++; $display("FAIL sw_mem_write_cycles: got %0d expected 4", mw);
    end
    checks++;
    if (pc_c !== 6) begin
      errors++; $display("FAIL sw_pc_write_cycle: got %0d expected 6", pc_c);
    end
    checks++;
    if ({rw, mr} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL sw_no_reg_write_or_read: got rw=%0d mr=%0d expected 0 0", rw, mr);
    end
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL sw_back_to_fetch: got %0d expected 0", state);
    end
  endtask

  task automatic test_load();
    do_reset();
    imem_rdata = 32'h00002183; imem_ready = 1'b1; mem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({state, mem_read, mem_write, alu_op, alu_src, reg_write} !== {3'd3, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lw_mem: got %b expected 0111000010", {state, mem_read, mem_write, alu_op, alu_src, reg_write});
    end
    tick();
    checks++;
    if ({state, mem_read, reg_write, mem_to_reg, pc_write} !== {3'd4, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL lw_wb: got %b expected 1000111", {state, mem_read, reg_write, mem_to_reg, pc_write});
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL lw_latency: got %0d expected 0", state);
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] words [10];
    logic [4:0]  exp   [10];
    words = '{32'h40000093, 32'h4030D093, 32'h0030D093, 32'h0020F0B3, 32'h0020B0B3,
              32'h4020D0B3, 32'h0020A0B3, 32'h0000C093, 32'h002090B3, 32'h0020E0B3};
    exp   = '{5'b0000_1, 5'b0111_1, 5'b0110_1, 5'b0010_0, 5'b1001_0,
              5'b0111_0, 5'b1000_0, 5'b0100_1, 5'b0101_0, 5'b0011_0};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      imem_rdata = words[i]; imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick();
      checks++;
      if ({alu_op, alu_src} !== exp[i]) begin
        errors++; $display("FAIL decode_%08h: got %b expected %b", words[i], {alu_op, alu_src}, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int good;
    good = 0;
    do_reset();
    imem_rdata = 32'h0000007F; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    checks++;
    if ({state, trap} !== {3'd7, 1'b1}) begin
      errors++; $display("FAIL illegal_trap: got %b expected 1111", {state, trap});
    end
    for (int c = 0; c < 20; c++) begin
      imem_ready = c[0];
      mem_ready = ~c[0];
      #1;
      if (trap && state == 3'd7 &&
          {imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, branch} == 7'b0) good++;
      tick();
    end
    checks++;
    if (good !== 20) begin
      errors++; $display("FAIL illegal_sticky: got %0d clean trap cycles expected 20", good);
    end
    imem_ready = 1'b0; mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({state, trap} !== 4'b0000) begin
      errors++; $display("FAIL illegal_reset_clear: got %b expected 0000", {state, trap});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({state, trap, imem_req} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL illegal_after_reset: got %b expected 00001", {state, trap, imem_req});
    end
  endtask

  task automatic test_timeout();
    // LOAD with data memory never ready: MEM occupies cycles 3..18, TRAP at 19.
    do_reset();
    imem_rdata = 32'h00002183; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int c = 1; c < 18; c++) tick();
    checks++;
    if ({state, mem_read, trap} !== {3'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tmo_last_mem_cycle: got %b expected 01110", {state, mem_read, trap});
    end
    tick();
    checks++;
    if ({state, trap, mem_read} !== {3'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tmo_trap: got %b expected 11110", {state, trap, mem_read});
    end
    // Ready arriving in the 16th MEM cycle still completes.
    do_reset();
    imem_rdata = 32'h00002183; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int c = 1; c < 18; c++) tick();
    mem_ready = 1'b1;
    tick();
    checks++;
    if ({state, reg_write, trap} !== {3'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tmo_ready_wins: got %b expected 10010", {state, reg_write, trap});
    end
    // Instruction memory never ready: TRAP entered at cycle 16.
    do_reset();
    for (int c = 0; c < 15; c++) tick();
    checks++;
    if ({state, imem_req} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL fetch_tmo_last_wait: got %b expected 0001", {state, imem_req});
    end
    tick();
    checks++;
    if ({state, imem_req, trap} !== {3'd7, 1'b0, 1'b1}) begin
      errors++; $display("FAIL fetch_tmo_trap: got %b expected 11101", {state, imem_req, trap});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_rdata = 32'h00002183; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({state, mem_read} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL areset_pre_mem: got %b expected 0111", {state, mem_read});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({state, alu_op, imem_req, ir_write, pc_write, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, trap} !== 17'b0) begin
      errors++; $display("FAIL areset_mid_mem: got %b expected 0", {state, alu_op, imem_req, ir_write, pc_write, reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch, trap});
    end
  endtask

  task automatic test_back_to_back();
    int pw, rw;
    pw = 0; rw = 0;
    do_reset();
    imem_ready = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      imem_rdata = (c < 4) ? 32'h00500113 : 32'h00208463;
      #1;
      if (pc_write) pw++;
      if (reg_write) rw++;
      if (c == 6) begin
        checks++;
        if ({state, branch, pc_write, alu_op, alu_src} !== {3'd2, 1'b1, 1'b1, 4'b0001, 1'b0}) begin
          errors++; $display("FAIL b2b_branch_exec: got %b expected 010110010", {state, branch, pc_write, alu_op, alu_src});
        end
      end
      if (c == 7) begin
        checks++;
        if (state !== 3'd0) begin
          errors++; $display("FAIL b2b_branch_latency: got %0d expected 0", state);
        end
      end
      tick();
    end
    checks++;
    if ({pw, rw} !== {32'd2, 32'd1}) begin
      errors++; $display("FAIL b2b_strobe_counts: got pc_write=%0d reg_write=%0d expected 2 1", pw, rw);
    end
  endtask

  initial begin
    reset = 1'b0; imem_rdata = 32'h0; imem_ready = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_sub();
    test_store_wait();
    test_load();
    test_decode_table();
    test_illegal();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
